// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-SRAM write bus of the program loader.
// The loader connects through the slave modport; the stream source / SRAM side uses master.
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        hold_fetch;
  logic        load_done;
  logic        load_error;

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_cs, mem_oe, mem_we, mem_addr, mem_din,
    output hold_fetch, load_done, load_error
  );

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_cs, mem_oe, mem_we, mem_addr, mem_din,
    input  hold_fetch, load_done, load_error
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: takes a 16-bit word count then big-endian packed words from a byte stream
// and writes them to the instruction SRAM from BASE_ADDR, holding fetch until done.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0020,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_din;

  logic        w_ready;
  logic        w_write;
  logic        w_hold;
  logic        w_done;
  logic        w_error;
  logic        w_xfer;
  logic        w_last_word;
  logic [15:0] w_hdr_count;

  assign w_xfer      = bus.byte_valid & w_ready;
  assign w_hdr_count = {r_count[15:8], bus.byte_in};
  assign w_last_word = (r_word_idx + 16'd1) == r_count;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_HDR0;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR0:  if (w_xfer) w_next = S_HDR1;
      S_HDR1:
        if (w_xfer) begin
          if (w_hdr_count == 16'd0)                  w_next = S_DONE;
          else if ({16'd0, w_hdr_count} > MAX_WORDS) w_next = S_ERROR;
          else                                       w_next = S_DATA;
        end
      S_DATA:  if (w_xfer && r_byte_cnt == 2'd3) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_DONE : S_DATA;
      S_DONE:  w_next = S_DONE;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_HDR0;
    endcase
  end

  // A reset asserted during the WRITE cycle suppresses that write.
  always_comb begin
    w_ready = 1'b0;
    w_write = 1'b0;
    w_hold  = 1'b1;
    w_done  = 1'b0;
    w_error = 1'b0;
    case (r_state)
      S_HDR0, S_HDR1, S_DATA: w_ready = 1'b1;
      S_WRITE: w_write = ~reset;
      S_DONE: begin
        w_hold = 1'b0;
        w_done = 1'b1;
      end
      S_ERROR: w_error = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= 16'd0;
      r_word_idx <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_addr     <= BASE_ADDR;
      r_din      <= 32'd0;
    end else begin
      if (r_state == S_HDR0 && w_xfer) r_count[15:8] <= bus.byte_in;
      if (r_state == S_HDR1 && w_xfer) r_count[7:0]  <= bus.byte_in;
      // Bytes shift in from the bottom, so byte 0 ends up in [31:24].
      if (r_state == S_DATA && w_xfer) begin
        r_din      <= {r_din[23:0], bus.byte_in};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (r_state == S_WRITE) begin
        r_word_idx <= r_word_idx + 16'd1;
        if (!w_last_word) r_addr <= r_addr + 32'd4;
      end
    end
  end

  assign bus.byte_ready = w_ready;
  assign bus.mem_cs     = w_write;
  assign bus.mem_we     = w_write;
  assign bus.mem_oe     = 1'b0;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_din    = r_din;
  assign bus.hold_fetch = w_hold;
  assign bus.load_done  = w_done;
  assign bus.load_error = w_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header handling, word packing, stalls, write bubble and reset abort.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  imem_loader_if bus ();

  imem_loader #(
    .BASE_ADDR(32'h0040_0020),
    .MAX_WORDS(1024)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wcyc[$];
  int          we_run = 0;
  int          bus_viol = 0;
  int          last_acc = 0;

  // Inputs change at negedge; sampling 1 time unit later sees what the SRAM sees at the next edge.
  always begin
    @(negedge clk);
    #1;
    if (bus.mem_cs !== bus.mem_we || bus.mem_oe !== 1'b0 || bus.mem_addr[1:0] !== 2'b00)
      bus_viol++;
    if (bus.mem_we === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_din);
      wcyc.push_back(cyc);
      we_run++;
      if (we_run > 1) bus_viol++;
    end else begin
      we_run = 0;
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wcyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents one byte starting at a negedge and returns at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", bus.byte_ready);
    end
    last_acc = cyc;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.byte_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.byte_ready); end
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_cs !== 1'b0 || bus.mem_oe !== 1'b0) begin n_err++; $display("FAIL rst_memctl: got cs=%b we=%b oe=%b want 000", bus.mem_cs, bus.mem_we, bus.mem_oe); end
    n_cmp++; if (bus.mem_addr !== 32'h0040_0020) begin n_err++; $display("FAIL rst_addr: got %h want 00400020", bus.mem_addr); end
    n_cmp++; if (bus.mem_din !== 32'h0) begin n_err++; $display("FAIL rst_din: got %h want 00000000", bus.mem_din); end
    n_cmp++; if (bus.hold_fetch !== 1'b1 || bus.load_done !== 1'b0 || bus.load_error !== 1'b0) begin n_err++; $display("FAIL rst_status: got hold=%b done=%b err=%b want 100", bus.hold_fetch, bus.load_done, bus.load_error); end
  endtask

  task automatic test_two_words();
    logic [7:0] s [10] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    do_reset();
    clear_log();
    for (int i = 0; i < 10; i++) begin
      send_byte(s[i]);
      if (i < 9) begin
        n_cmp++; if (bus.load_done !== 1'b0 || bus.hold_fetch !== 1'b1) begin n_err++; $display("FAIL two_early_done: byte %0d done=%b hold=%b want 0/1", i, bus.load_done, bus.hold_fetch); end
      end
    end
    idle(3);
    n_cmp++; if (wa.size() !== 2) begin n_err++; $display("FAIL two_count: got %0d writes want 2", wa.size()); end
    else begin
      n_cmp++; if (wa[0] !== 32'h0040_0020 || wd[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL two_w0: got %h@%h want deadbeef@00400020", wd[0], wa[0]); end
      n_cmp++; if (wa[1] !== 32'h0040_0024 || wd[1] !== 32'h0123_4567) begin n_err++; $display("FAIL two_w1: got %h@%h want 01234567@00400024", wd[1], wa[1]); end
    end
    n_cmp++; if (bus.load_done !== 1'b1 || bus.hold_fetch !== 1'b0 || bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL two_done: got done=%b hold=%b ready=%b want 1/0/0", bus.load_done, bus.hold_fetch, bus.byte_ready); end
    // Trailing bytes after the image are refused.
    bus.byte_in = 8'h99;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.byte_ready !== 1'b0 || bus.load_done !== 1'b1) begin n_err++; $display("FAIL two_trailing: got ready=%b done=%b want 0/1", bus.byte_ready, bus.load_done); end
    idle(1);
  endtask

  task automatic test_zero_count();
    do_reset();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h00);
    n_cmp++; if (bus.load_done !== 1'b1 || bus.hold_fetch !== 1'b0) begin n_err++; $display("FAIL zero_done: got done=%b hold=%b want 1/0", bus.load_done, bus.hold_fetch); end
    idle(4);
    n_cmp++; if (wa.size() !== 0) begin n_err++; $display("FAIL zero_writes: got %0d writes want 0", wa.size()); end
  endtask

  task automatic test_overflow();
    int refused = 0;
    do_reset();
    clear_log();
    send_byte(8'h04);
    send_byte(8'h01);
    n_cmp++; if (bus.load_error !== 1'b1 || bus.hold_fetch !== 1'b1 || bus.byte_ready !== 1'b0) begin n_err++; $display("FAIL ovf_state: got err=%b hold=%b ready=%b want 1/1/0", bus.load_error, bus.hold_fetch, bus.byte_ready); end
    bus.byte_in = 8'h5A;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b0) refused++;
    end
    idle(1);
    n_cmp++; if (refused !== 6) begin n_err++; $display("FAIL ovf_refuse: got %0d refused cycles want 6", refused); end
    n_cmp++; if (wa.size() !== 0 || bus.load_done !== 1'b0 || bus.load_error !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got writes=%0d done=%b err=%b want 0/0/1", wa.size(), bus.load_done, bus.load_error); end
  endtask

  task automatic test_stall();
    logic [6:0] vpat = 7'b1001011;
    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int k = 0;
    int acc = 0;
    do_reset();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 0; i < 7; i++) begin
      bus.byte_valid = vpat[6 - i];
      bus.byte_in = vpat[6 - i] ? dat[k] : 8'hFF;
      if (vpat[6 - i]) begin
        acc = cyc;
        k++;
      end
      @(negedge clk);
    end
    idle(3);
    n_cmp++; if (wa.size() !== 1) begin n_err++; $display("FAIL stall_count: got %0d writes want 1", wa.size()); end
    else begin
      n_cmp++; if (wd[0] !== 32'h1122_3344 || wa[0] !== 32'h0040_0020) begin n_err++; $display("FAIL stall_data: got %h@%h want 11223344@00400020", wd[0], wa[0]); end
      n_cmp++; if (wcyc[0] !== acc + 1) begin n_err++; $display("FAIL stall_latency: write in cycle %0d want %0d", wcyc[0], acc + 1); end
    end
  endtask

  task automatic test_back_to_back();
    int acc4 = 0;
    do_reset();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    acc4 = last_acc;
    // Now in the WRITE cycle; the next byte is held valid across it.
    bus.byte_in = 8'h55;
    bus.byte_valid = 1'b1;
    n_cmp++; if (bus.byte_ready !== 1'b0 || bus.mem_we !== 1'b1) begin n_err++; $display("FAIL b2b_bubble: got ready=%b we=%b want 0/1", bus.byte_ready, bus.mem_we); end
    send_byte(8'h55);
    n_cmp++; if (last_acc !== acc4 + 2) begin n_err++; $display("FAIL b2b_resume: next byte in cycle %0d want %0d", last_acc, acc4 + 2); end
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    idle(3);
    n_cmp++; if (wa.size() !== 2) begin n_err++; $display("FAIL b2b_count: got %0d writes want 2", wa.size()); end
    else begin
      n_cmp++; if (wd[0] !== 32'h1122_3344 || wd[1] !== 32'h5566_7788 || wa[1] !== 32'h0040_0024) begin n_err++; $display("FAIL b2b_data: got %h, %h@%h want 11223344, 55667788@00400024", wd[0], wd[1], wa[1]); end
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h12);
    send_byte(8'h34);
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    idle(3);
    n_cmp++; if (wa.size() !== 1) begin n_err++; $display("FAIL abort_count: got %0d writes want 1", wa.size()); end
    else begin
      n_cmp++; if (wd[0] !== 32'hAABB_CCDD || wa[0] !== 32'h0040_0020) begin n_err++; $display("FAIL abort_data: got %h@%h want aabbccdd@00400020", wd[0], wa[0]); end
    end
    n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL abort_done: got %b want 1", bus.load_done); end
  endtask

  task automatic test_reset_in_write();
    do_reset();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hC0);
    send_byte(8'hFF);
    send_byte(8'hEE);
    send_byte(8'h01);
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_cs !== 1'b0) begin n_err++; $display("FAIL rstw_suppress: got cs=%b we=%b want 0/0", bus.mem_cs, bus.mem_we); end
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (bus.byte_ready !== 1'b1 || bus.mem_din !== 32'h0 || bus.load_done !== 1'b0) begin n_err++; $display("FAIL rstw_restart: got ready=%b din=%h done=%b want 1/00000000/0", bus.byte_ready, bus.mem_din, bus.load_done); end
    idle(3);
    n_cmp++; if (wa.size() !== 0) begin n_err++; $display("FAIL rstw_writes: got %0d writes want 0", wa.size()); end
  endtask

  initial begin
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_two_words();
    test_zero_count();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_reset_in_write();
    n_cmp++; if (bus_viol !== 0) begin n_err++; $display("FAIL bus_rules: got %0d cs/we/oe/align/pulse violations want 0", bus_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
